branch_predict_unit: RTL and testbench

Parametrised branch predictor and next-PC selector for the five-stage pipelined CPU. It replaces the fixed "predict not-taken, redirect on MEM-stage Branch" path with a configurable direction predictor: static, bimodal 2-bit, or gshare. It sits in the IF stage for lookup and receives resolved outcomes from the MEM stage. It produces the next PC, a flush for wrong-path instructions, and the table index that travels down the pipe with each branch.

---
 rtl/bpu_pkg.sv | 37 +++
 rtl/sat_counter2.sv | 46 ++++
 rtl/branch_predict_unit.sv | 138 +++++++++++++
 tb/tb_branch_predict_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bpu_pkg
// Description : Shared definitions for the branch predictor: mode
//               encodings, the 2-bit counter type, counter state
//               constants and the saturating step function.
// Revision    : 1.0 - initial release
// ============================================================================
package bpu_pkg;

    // Direction-predictor modes
    localparam int BPU_STATIC  = 0;
    localparam int BPU_BIMODAL = 1;
    localparam int BPU_GSHARE  = 2;

    // 2-bit direction counter
    typedef logic [1:0] cnt2_t;

    localparam cnt2_t SNT = 2'd0;
    localparam cnt2_t WNT = 2'd1;
    localparam cnt2_t WT  = 2'd2;
    localparam cnt2_t ST  = 2'd3;

    // One saturating step toward taken (up=1) or not-taken (up=0)
    function automatic cnt2_t sat_step(input cnt2_t cnt, input logic up);
        cnt2_t res;
        res = cnt;
        if (up && (cnt != ST)) begin
            res = cnt + 2'd1;
        end else if (!up && (cnt != SNT)) begin
            res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter2.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter2
// Description : 2-bit saturating up/down counter, one entry of the
//               branch direction table.
// Revision    : 1.0 - initial release
// Ports       : clk_i  - clock, rising edge
//               rst_i  - asynchronous active-low reset (loads INIT_CNT)
//               en_i   - apply one step this cycle
//               up_i   - 1: count toward taken, 0: toward not-taken
//               cnt_o  - current counter value
// ============================================================================
module sat_counter2
    import bpu_pkg::*;
#(
    parameter cnt2_t INIT_CNT = WNT
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  en_i,
    input  logic  up_i,
    output cnt2_t cnt_o
);

    cnt2_t cnt_q;
    cnt2_t cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = sat_step(cnt_q, up_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= INIT_CNT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit
// Description : Branch direction predictor and next-PC selector. Looks up
//               a table of 2-bit counters in IF (static, bimodal or gshare
//               indexing), and takes resolved outcomes from MEM to train
//               the table and raise a flush on mispredict.
// Revision    : 1.0 - initial release
// Config      : BPU_STATS_EN - when defined, builds the 32-bit resolved
//               branch and mispredict counters; otherwise both stat
//               outputs are tied to zero.
// Ports       : clk_i, rst_i (async active-low)
//               if_pc_i / if_branch_i / if_target_i - IF-stage lookup
//               pred_taken_o / pred_idx_o / next_pc_o  - prediction, index
//               res_*_i                                - MEM resolution
//               flush_o                                - mispredict squash
//               stat_branches_o / stat_mispred_o        - statistics
// ============================================================================
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int    PC_W     = 32,
    parameter int    IDX_W    = 6,
    parameter int    HIST_W   = 6,
    parameter int    MODE     = 1,
    parameter cnt2_t INIT_CNT = 2'b01
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [PC_W-1:0]   if_pc_i,
    input  logic              if_branch_i,
    input  logic [PC_W-1:0]   if_target_i,
    output logic              pred_taken_o,
    output logic [IDX_W-1:0]  pred_idx_o,
    output logic [PC_W-1:0]   next_pc_o,
    input  logic              res_valid_i,
    input  logic [PC_W-1:0]   res_pc_i,
    input  logic [IDX_W-1:0]  res_idx_i,
    input  logic              res_pred_i,
    input  logic              res_taken_i,
    input  logic [PC_W-1:0]   res_target_i,
    output logic              flush_o,
    output logic [31:0]       stat_branches_o,
    output logic [31:0]       stat_mispred_o
);

    logic [IDX_W-1:0] pc_idx;
    logic [PC_W-1:0]  redirect_pc;

    // Word-aligned PC bits select the table entry
    assign pc_idx = if_pc_i[IDX_W+1:2];

    generate
        if (MODE == BPU_STATIC) begin : g_static
            assign pred_idx_o   = pc_idx;
            assign pred_taken_o = 1'b0;
        end else begin : g_table
            cnt2_t            cnt_tbl [2**IDX_W];
            logic [IDX_W-1:0] lookup_idx;

            if (MODE == BPU_GSHARE) begin : g_gshare
                logic [HIST_W-1:0] ghr_q;
                logic [HIST_W-1:0] ghr_d;

                // Shift in the resolved outcome; the cast drops the oldest bit
                assign ghr_d = res_valid_i ? HIST_W'({ghr_q, res_taken_i}) : ghr_q;

                always_ff @(posedge clk_i or negedge rst_i) begin
                    if (!rst_i) begin
                        ghr_q <= '0;
                    end else begin
                        ghr_q <= ghr_d;
                    end
                end

                assign lookup_idx = pc_idx ^ IDX_W'(ghr_q);
            end else begin : g_bimodal
                assign lookup_idx = pc_idx;
            end

            // Training uses the index captured at fetch, not the current one
            for (genvar i = 0; i < 2**IDX_W; i++) begin : g_cnt
                sat_counter2 #(
                    .INIT_CNT (INIT_CNT)
                ) u_cnt (
                    .clk_i (clk_i),
                    .rst_i (rst_i),
                    .en_i  (res_valid_i && (res_idx_i == IDX_W'(i))),
                    .up_i  (res_taken_i),
                    .cnt_o (cnt_tbl[i])
                );
            end

            // Lookup reads the registered table: no same-cycle bypass
            assign pred_idx_o   = lookup_idx;
            assign pred_taken_o = if_branch_i & cnt_tbl[lookup_idx][1];
        end
    endgenerate

    assign flush_o     = res_valid_i & (res_taken_i != res_pred_i);
    assign redirect_pc = res_taken_i ? res_target_i : (res_pc_i + PC_W'(4));

    always_comb begin
        next_pc_o = if_pc_i + PC_W'(4);
        if (flush_o) begin
            next_pc_o = redirect_pc;
        end else if (pred_taken_o) begin
            next_pc_o = if_target_i;
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (res_valid_i) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (flush_o) begin
                stat_mp_q <= stat_mp_q + 32'd1;
            end
        end
    end

    assign stat_branches_o = stat_br_q;
    assign stat_mispred_o  = stat_mp_q;
`else
    assign stat_branches_o = '0;
    assign stat_mispred_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_unit
// Description : Directed testbench for branch_predict_unit. A bimodal
//               instance and a gshare instance (HIST_W=2) share stimulus;
//               expected values are queued as each step is driven and
//               compared when the outputs settle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] if_pc_i;
    logic        if_branch_i;
    logic [31:0] if_target_i;
    logic        res_valid_i;
    logic [31:0] res_pc_i;
    logic [5:0]  res_idx_i;
    logic        res_pred_i;
    logic        res_taken_i;
    logic [31:0] res_target_i;

    logic        pred_taken, flush;
    logic [5:0]  pred_idx;
    logic [31:0] next_pc, stat_br, stat_mp;

    logic        g_pred_taken, g_flush;
    logic [5:0]  g_pred_idx;
    logic [31:0] g_next_pc, g_stat_br, g_stat_mp;

    int checks = 0;
    int errors = 0;
    int m_br   = 0;
    int m_mp   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    branch_predict_unit #(
        .PC_W(32), .IDX_W(6), .HIST_W(6), .MODE(1), .INIT_CNT(2'b01)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_pc_i(if_pc_i), .if_branch_i(if_branch_i), .if_target_i(if_target_i),
        .pred_taken_o(pred_taken), .pred_idx_o(pred_idx), .next_pc_o(next_pc),
        .res_valid_i(res_valid_i), .res_pc_i(res_pc_i), .res_idx_i(res_idx_i),
        .res_pred_i(res_pred_i), .res_taken_i(res_taken_i), .res_target_i(res_target_i),
        .flush_o(flush), .stat_branches_o(stat_br), .stat_mispred_o(stat_mp)
    );

    branch_predict_unit #(
        .PC_W(32), .IDX_W(6), .HIST_W(2), .MODE(2), .INIT_CNT(2'b01)
    ) dut_g (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_pc_i(if_pc_i), .if_branch_i(if_branch_i), .if_target_i(if_target_i),
        .pred_taken_o(g_pred_taken), .pred_idx_o(g_pred_idx), .next_pc_o(g_next_pc),
        .res_valid_i(res_valid_i), .res_pc_i(res_pc_i), .res_idx_i(res_idx_i),
        .res_pred_i(res_pred_i), .res_taken_i(res_taken_i), .res_target_i(res_target_i),
        .flush_o(g_flush), .stat_branches_o(g_stat_br), .stat_mispred_o(g_stat_mp)
    );

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=0x%0h expected=<queued value>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive_if(input logic [31:0] pc, input logic br, input logic [31:0] tgt);
        if_pc_i     = pc;
        if_branch_i = br;
        if_target_i = tgt;
    endtask

    task automatic drive_res(input logic [5:0] idx, input logic [31:0] pc,
                             input logic pred, input logic taken, input logic [31:0] tgt);
        res_valid_i  = 1'b1;
        res_idx_i    = idx;
        res_pc_i     = pc;
        res_pred_i   = pred;
        res_taken_i  = taken;
        res_target_i = tgt;
        m_br++;
        if (pred != taken) m_mp++;
    endtask

    task automatic close_cycle();
        @(posedge clk_i);
        #1;
        res_valid_i = 1'b0;
    endtask

    // Bimodal instance: prediction, next PC, flush and index
    task automatic chk_main(input string t, input logic ep, input logic [31:0] enext, input logic ef);
        logic [5:0] eidx;
        eidx = if_pc_i[7:2];
        push({t, ".pred"},  32'(ep));
        push({t, ".next"},  enext);
        push({t, ".flush"}, 32'(ef));
        push({t, ".idx"},   32'(eidx));
        #1;
        pop_check(32'(pred_taken));
        pop_check(next_pc);
        pop_check(32'(flush));
        pop_check(32'(pred_idx));
    endtask

    task automatic chk_g(input string t, input logic ep, input logic [5:0] eidx);
        push({t, ".gpred"}, 32'(ep));
        push({t, ".gidx"},  32'(eidx));
        #1;
        pop_check(32'(g_pred_taken));
        pop_check(32'(g_pred_idx));
    endtask

    task automatic chk_stats(input string t);
`ifdef BPU_STATS_EN
        push({t, ".branches"}, 32'(m_br));
        push({t, ".mispred"},  32'(m_mp));
`else
        push({t, ".branches"}, 32'd0);
        push({t, ".mispred"},  32'd0);
`endif
        #1;
        pop_check(stat_br);
        pop_check(stat_mp);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=no finish expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i        = 1'b0;
        res_valid_i  = 1'b0;
        res_pc_i     = '0;
        res_idx_i    = '0;
        res_pred_i   = 1'b0;
        res_taken_i  = 1'b0;
        res_target_i = '0;
        drive_if(32'h40, 1'b1, 32'h100);

        // Reset state: counters weakly not-taken, stats zero
        #2;
        chk_main("reset", 1'b0, 32'h44, 1'b0);
        chk_stats("reset");
        @(negedge clk_i);
        rst_i = 1'b1;

        @(negedge clk_i);
        drive_if(32'h40, 1'b1, 32'h100);
        chk_main("lookup0", 1'b0, 32'h44, 1'b0);

        // First taken resolve: lookup in the same cycle still sees WNT
        @(negedge clk_i);
        drive_if(32'h40, 1'b1, 32'h100);
        drive_res(6'h10, 32'h40, 1'b0, 1'b1, 32'h200);
        chk_main("res_t1", 1'b0, 32'h200, 1'b1);
        close_cycle();

        @(negedge clk_i);
        drive_if(32'h40, 1'b1, 32'h100);
        chk_main("after_t1", 1'b1, 32'h100, 1'b0);

        @(negedge clk_i);
        drive_if(32'h40, 1'b1, 32'h100);
        drive_res(6'h10, 32'h40, 1'b0, 1'b1, 32'h200);
        chk_main("res_t2", 1'b1, 32'h200, 1'b1);
        close_cycle();

        // Counter is at ST; more taken outcomes must saturate
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            drive_if(32'h40, 1'b1, 32'h100);
            drive_res(6'h10, 32'h40, 1'b1, 1'b1, 32'h200);
            chk_main("sat_t", 1'b1, 32'h100, 1'b0);
            close_cycle();
        end

        // Not-taken mispredict at 0x7C overrides IF-side predicted target
        @(negedge clk_i);
        drive_if(32'h40, 1'b1, 32'h100);
        drive_res(6'h1F, 32'h7C, 1'b1, 1'b0, 32'h300);
        chk_main("mis_7c", 1'b1, 32'h80, 1'b1);
        close_cycle();

        // ST -> WT: still predicts taken
        @(negedge clk_i);
        drive_if(32'h1000, 1'b0, 32'h100);
        drive_res(6'h10, 32'h40, 1'b1, 1'b0, 32'h200);
        chk_main("res_nt1", 1'b0, 32'h44, 1'b1);
        close_cycle();

        @(negedge clk_i);
        drive_if(32'h40, 1'b1, 32'h100);
        chk_main("after_nt1", 1'b1, 32'h100, 1'b0);

        @(negedge clk_i);
        drive_if(32'h40, 1'b0, 32'h100);
        chk_main("nobranch", 1'b0, 32'h44, 1'b0);

        // WT -> WNT: prediction flips to not-taken
        @(negedge clk_i);
        drive_if(32'h1000, 1'b0, 32'h100);
        drive_res(6'h10, 32'h40, 1'b1, 1'b0, 32'h200);
        chk_main("res_nt2", 1'b0, 32'h44, 1'b1);
        close_cycle();

        @(negedge clk_i);
        drive_if(32'h40, 1'b1, 32'h100);
        chk_main("after_nt2", 1'b0, 32'h44, 1'b0);

        // PC wrap on both the sequential and redirect paths
        @(negedge clk_i);
        drive_if(32'hFFFF_FFFC, 1'b0, 32'h100);
        chk_main("wrap_seq", 1'b0, 32'h0, 1'b0);

        @(negedge clk_i);
        drive_if(32'h1000, 1'b0, 32'h100);
        drive_res(6'h3F, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h500);
        chk_main("wrap_redir", 1'b0, 32'h0, 1'b1);
        close_cycle();

        @(negedge clk_i);
        chk_stats("stats_run");

        // Asynchronous reset mid-cycle clears stats and table immediately
        #2;
        rst_i = 1'b0;
        m_br  = 0;
        m_mp  = 0;
        drive_if(32'h40, 1'b1, 32'h100);
        chk_stats("stats_rst");
        chk_main("table_rst", 1'b0, 32'h44, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // gshare: history starts at zero
        @(negedge clk_i);
        drive_if(32'h0, 1'b1, 32'h100);
        chk_g("g_init", 1'b0, 6'h00);

        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            drive_res(6'h05, 32'h14, 1'b0, 1'b1, 32'h200);
            close_cycle();
        end

        // ghr = 2'b11: PC 0 maps to index 3, which was never trained
        @(negedge clk_i);
        drive_if(32'h0, 1'b1, 32'h100);
        chk_g("g_hist11", 1'b0, 6'h03);

        // Training went to the captured index 5 (PC 0x18 ^ 3)
        @(negedge clk_i);
        drive_if(32'h18, 1'b1, 32'h100);
        chk_g("g_idx5", 1'b1, 6'h05);
        push("g_idx5.next", 32'h100);
        pop_check(g_next_pc);

        @(negedge clk_i);
        drive_res(6'h05, 32'h14, 1'b1, 1'b0, 32'h200);
        close_cycle();

        @(negedge clk_i);
        drive_if(32'h0, 1'b1, 32'h100);
        chk_g("g_hist10", 1'b0, 6'h02);

        @(negedge clk_i);
        chk_stats("stats_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
